opb_status_bank: RTL and testbench
==================================

# opb_status_bank

Parametrised multi-channel successor to the single-word simulink-to-PPC status register: `C_NUM_CH` 32-bit status words from user logic readable over the OPB slave bus. Adds per-channel sticky (OR-accumulate) mode, an atomic snapshot of all channels (software- or user-triggered), and a control/status word. Sits on the OPB bus alongside the other software registers; user logic is synchronous to `OPB_Clk`.

## Interface
- `C_BASEADDR`, 32'h01100100, first byte of window
- `C_HIGHADDR`, 32'h011001FF, last byte of window; window ≥ 4*(C_NUM_CH+1) bytes
- `C_OPB_AWIDTH`, 32, OPB address width
- `C_OPB_DWIDTH`, 32, OPB data width (fixed 32)
- `C_NUM_CH`, 4, channel count, 1..32
- `C_STICKY_CH`, 0, C_NUM_CH-bit vector; bit i=1 makes channel i sticky
- `C_FAMILY`, "virtex6", target family (informational)
- `OPB_Clk`  in  1  sole clock, all logic rising-edge
- `OPB_Rst`  in  1  asynchronous, active-high reset
- `OPB_ABus`  in  [0:31]  address
- `OPB_BE`  in  [0:3]  byte enables
- `OPB_DBus`  in  [0:31]  write data
- `OPB_RNW`  in  1  1=read, 0=write
- `OPB_select`  in  1  transfer request
- `OPB_seqAddr`  in  1  ignored
- `Sl_DBus`  out  [0:31]  read data, zero when not acking
- `Sl_xferAck`  out  1  one-cycle transfer acknowledge
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`  out  1 each  tied 0
- `user_data_in`  in  C_NUM_CH*32  channel i at bits [32i+31:32i]
- `user_snap`  in  1  single-cycle snapshot strobe from user logic

## Operation
- Bit numbering below is value-weighted: bit0 = LSB = `OPB_DBus[31]`.
- Capture stage `cap[i]`, updated every cycle: non-sticky: `cap[i] <= user_data_in[i]`; sticky: `cap[i] <= cap[i] | user_data_in[i]`.
- CLR_STICKY: sticky channels load `cap[i] <= user_data_in[i]` (new-data-set wins over clear in the same cycle); non-sticky unaffected.
- Snapshot: all `snap[i] <= cap[i]` in one cycle; `snap_cnt` (16 bit, wraps 0xFFFF->0) increments by 1. `user_snap` and CTRL SNAP in the same cycle -> one snapshot, +1.
- Address map (word offset = (OPB_ABus - C_BASEADDR) >> 2): 0..C_NUM_CH-1 channel words; C_NUM_CH = CTRL; other in-window offsets read 0, writes ignored. Writes to channel words ignored (acked).
- Channel read: LIVE=1 returns `cap[i]`; LIVE=0 returns `snap[i]`.
- CTRL write (effective only if `OPB_BE[3]`=1): bit0 SNAP pulse, bit1 CLR_STICKY pulse, bit2 LIVE (persistent). Pulse bits self-clear.
- CTRL read: [31:16] snap_cnt, [15:8] C_NUM_CH, [2] LIVE, others 0.
- Bus FSM: IDLE -> ACK when `OPB_select` and address in [C_BASEADDR, C_HIGHADDR]; ACK -> HOLD; HOLD -> IDLE. Out-of-window selects ignored.
- Reset values: cap, snap, snap_cnt = 0; LIVE = 1; FSM IDLE; Sl_DBus = 0; Sl_xferAck = 0.

## Timing
- Decode at the IDLE->ACK edge; `Sl_xferAck` and `Sl_DBus` high/valid during ACK only (cycle after select sampled); zero otherwise.
- Read data registered at the IDLE->ACK edge from the value visible before that edge.
- CTRL write side effects (SNAP, CLR_STICKY, LIVE) apply at the IDLE->ACK edge; a following transaction sees them.
- HOLD blocks re-decode for one cycle so a held `OPB_select` never double-acks; minimum transfer spacing 3 cycles.
- `user_data_in` -> `cap` latency 1 cycle; snapshot captures `cap` (input of the previous cycle).
- Reset asserted mid-transfer: `Sl_xferAck`, `Sl_DBus` drop immediately; FSM IDLE; pending pulses discarded.

## Test plan
- Reset, read CTRL at offset C_NUM_CH -> 0x00000404 (count 0, NUM_CH 4, LIVE 1); one-cycle ack, Sl_DBus 0 outside ack.
- LIVE=1, drive ch2=0xDEADBEEF, read offset 2 -> 0xDEADBEEF; held `OPB_select` for 6 cycles -> exactly 2 acks.
- C_STICKY_CH=4'b0001: pulse ch0 bit3 then bit7 -> read 0x88; write CTRL 0x6 with ch0=0x01 in that cycle -> read 0x01.
- Write CTRL 0x0 (LIVE=0), pulse `user_snap` with ch1=0x1234; change ch1 to 0x5678 -> read ch1 = 0x1234, CTRL[31:16]=1.
- `user_snap` coincident with CTRL SNAP -> snap_cnt +1; 0x10000 snapshots -> count wraps to 0.
- Assert `OPB_Rst` during ACK -> Sl_xferAck low same cycle, all registers at reset values; out-of-window read -> no ack.

Source files
------------

// File: rtl/opb_status_bank.sv
// opb_status_bank: multi-channel OPB status register bank.
// Sticky capture, atomic snapshot, and a control/status word.
//
// Ports:
//   OPB_Clk, OPB_Rst        clock, async active-high reset
//   OPB_ABus/BE/DBus/RNW    OPB slave request (IBM bit order, [0] = MSB)
//   OPB_select, OPB_seqAddr transfer request (seqAddr unused)
//   Sl_DBus, Sl_xferAck     registered read data and one-cycle ack
//   Sl_errAck/retry/toutSup tied low
//   user_data_in            C_NUM_CH x 32-bit status words, ch i at [32i+:32]
//   user_snap               single-cycle snapshot strobe
module opb_status_bank #(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0110_0100,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0110_01FF,
    parameter int                      C_NUM_CH     = 4,
    parameter logic [C_NUM_CH-1:0]     C_STICKY_CH  = '0,
    parameter                          C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_NUM_CH*32-1:0]    user_data_in,
    input  logic                      user_snap
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_HOLD
    } state_t;

    localparam bit FAMILY_SET = (C_FAMILY != "");

    state_t state_q;
    logic   xfer_ack_q;
    logic [31:0] dbus_q;

    logic [C_NUM_CH-1:0][31:0] cap_q, cap_d;
    logic [C_NUM_CH-1:0][31:0] snap_q, snap_d;
    logic [15:0] snap_cnt_q, snap_cnt_d;
    logic        live_q, live_d;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_AWIDTH-1:0] rel;
    logic [C_OPB_AWIDTH-1:0] off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        in_win;
    logic        is_ctrl;
    logic        accept;
    logic        wr_ctrl;
    logic        do_snap;
    logic        do_clr;
    logic        unused_ok;

    // Vector assignment keeps MSB on MSB, so addr/wdata are value-weighted.
    assign addr   = OPB_ABus;
    assign wdata  = OPB_DBus;
    assign rel    = addr - C_BASEADDR;
    assign off    = rel >> 2;
    assign in_win = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign is_ctrl = (off == C_OPB_AWIDTH'(C_NUM_CH));
    assign accept = (state_q == ST_IDLE) && OPB_select && in_win;

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = xfer_ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3], FAMILY_SET};

    // Read mux: sees register values from before the decode edge.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (off == C_OPB_AWIDTH'(i)) begin
                rdata = live_q ? cap_q[i] : snap_q[i];
            end
        end
        if (is_ctrl) begin
            rdata = {snap_cnt_q, 8'(C_NUM_CH), 5'b0, live_q, 2'b0};
        end
    end

    // Control side effects take hold on the same edge that decodes the write.
    always_comb begin
        wr_ctrl = accept && !OPB_RNW && is_ctrl && OPB_BE[3];
        do_snap = user_snap || (wr_ctrl && wdata[0]);
        do_clr  = wr_ctrl && wdata[1];
        live_d  = wr_ctrl ? wdata[2] : live_q;
        snap_cnt_d = snap_cnt_q + {15'b0, do_snap};
        cap_d  = cap_q;
        snap_d = snap_q;
        for (int i = 0; i < C_NUM_CH; i++) begin
            // A clear reloads with this cycle's data rather than zero.
            if (C_STICKY_CH[i] && !do_clr) begin
                cap_d[i] = cap_q[i] | user_data_in[32*i +: 32];
            end else begin
                cap_d[i] = user_data_in[32*i +: 32];
            end
            if (do_snap) begin
                snap_d[i] = cap_q[i];
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            cap_q      <= '0;
            snap_q     <= '0;
            snap_cnt_q <= '0;
            live_q     <= 1'b1;
        end else begin
            cap_q      <= cap_d;
            snap_q     <= snap_d;
            snap_cnt_q <= snap_cnt_d;
            live_q     <= live_d;
        end
    end

    // HOLD keeps a held select from being decoded twice.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q    <= ST_IDLE;
            xfer_ack_q <= 1'b0;
            dbus_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_ACK;
                        xfer_ack_q <= 1'b1;
                        dbus_q     <= OPB_RNW ? rdata : 32'h0;
                    end
                end
                ST_ACK: begin
                    state_q    <= ST_HOLD;
                    xfer_ack_q <= 1'b0;
                    dbus_q     <= '0;
                end
                ST_HOLD: begin
                    state_q    <= ST_IDLE;
                    xfer_ack_q <= 1'b0;
                    dbus_q     <= '0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    xfer_ack_q <= 1'b0;
                    dbus_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_status_bank.sv
// tb_opb_status_bank: directed + random checks of opb_status_bank
// against a cycle-level behavioural model of the status bank.
module tb_opb_status_bank;

    localparam logic [31:0] BASE   = 32'h0110_0100;
    localparam logic [31:0] HIGH   = 32'h0110_01FF;
    localparam logic [31:0] CTRLA  = BASE + 32'd16;
    localparam int          NCH    = 4;
    localparam logic [3:0]  STICKY = 4'b0001;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         sel;
    logic         seqaddr;
    logic [0:31]  sl_dbus;
    logic         ack;
    logic         errack;
    logic         retry;
    logic         tout;
    logic [127:0] udin;
    logic         usnap;
    logic [31:0]  din [NCH];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the bank.
    logic [31:0] m_cap  [NCH];
    logic [31:0] m_snap [NCH];
    int          m_cnt;
    logic        m_live;
    int          m_cool;
    logic        e_ack;
    logic        e_rnw;
    logic [31:0] e_rd;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) udin[32*i +: 32] = din[i];
    end

    opb_status_bank #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH),
        .C_NUM_CH   (NCH),
        .C_STICKY_CH(STICKY)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seqaddr),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (ack),
        .Sl_errAck   (errack),
        .Sl_retry    (retry),
        .Sl_toutSup  (tout),
        .user_data_in(udin),
        .user_snap   (usnap)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cap[i]  = '0;
            m_snap[i] = '0;
        end
        m_cnt  = 0;
        m_live = 1'b1;
        m_cool = 0;
    endtask

    function automatic logic [31:0] mread(input logic [31:0] off);
        logic [15:0] c;
        c = m_cnt[15:0];
        if (off < NCH) return m_live ? m_cap[off] : m_snap[off];
        if (off == NCH) return {c, 8'd4, 5'd0, m_live, 2'd0};
        return 32'h0;
    endfunction

    // One clock: predict from the rules, advance, compare bus outputs.
    task automatic step();
        logic [31:0] a, off, wv;
        logic [31:0] ncap [NCH];
        logic acc, wr, sn, clr;
        a   = abus;
        wv  = dbus;
        off = (a - BASE) / 4;
        acc = (m_cool == 0) && sel && (a >= BASE) && (a <= HIGH);
        e_ack = acc;
        e_rnw = rnw;
        e_rd  = (acc && rnw) ? mread(off) : 32'h0;
        wr  = acc && !rnw && (off == NCH) && be[3];
        sn  = usnap || (wr && wv[0]);
        clr = wr && wv[1];
        for (int i = 0; i < NCH; i++) begin
            ncap[i] = (STICKY[i] && !clr) ? (m_cap[i] | din[i]) : din[i];
            if (sn) m_snap[i] = m_cap[i];
        end
        for (int i = 0; i < NCH; i++) m_cap[i] = ncap[i];
        if (sn) m_cnt = (m_cnt + 1) % 65536;
        if (wr) m_live = wv[2];
        m_cool = acc ? 2 : (m_cool > 0 ? m_cool - 1 : 0);
        @(posedge clk);
        #1;
        chk("ack", {31'b0, ack}, {31'b0, e_ack});
        if (!(e_ack && !e_rnw)) chk("dbus", sl_dbus, e_rd);
    endtask

    task automatic xact(input logic [31:0] a, input logic r,
                        input logic [31:0] wd, input logic [0:3] b,
                        output logic [31:0] rd, output logic acked);
        abus = a;
        rnw  = r;
        dbus = wd;
        be   = b;
        sel  = 1'b1;
        step();
        acked = ack;
        rd    = sl_dbus;
        sel  = 1'b0;
        rnw  = 1'b1;
        dbus = '0;
        be   = '0;
        step();
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;
        int          nack;
        rst = 1'b1;
        abus = '0;
        be = '0;
        dbus = '0;
        rnw = 1'b1;
        sel = 1'b0;
        seqaddr = 1'b0;
        usnap = 1'b0;
        for (int i = 0; i < NCH; i++) din[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_dbus", sl_dbus, 32'h0);
        rst = 1'b0;

        xact(CTRLA, 1'b1, 0, 4'b0000, rd, ak);
        chk("ctrl_ack", {31'b0, ak}, 32'h1);
        chk("ctrl_rst", rd, 32'h0000_0404);

        din[2] = 32'hDEAD_BEEF;
        step();
        xact(BASE + 8, 1'b1, 0, 4'b0000, rd, ak);
        chk("live_ch2", rd, 32'hDEAD_BEEF);

        abus = BASE + 8;
        rnw = 1'b1;
        sel = 1'b1;
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ack) nack++;
        end
        sel = 1'b0;
        step();
        chk("held_acks", nack, 32'd2);

        din[0] = 32'h08;
        step();
        din[0] = 32'h80;
        step();
        din[0] = 32'h00;
        step();
        xact(BASE, 1'b1, 0, 4'b0000, rd, ak);
        chk("sticky_or", rd, 32'h88);
        din[0] = 32'h01;
        xact(CTRLA, 1'b0, 32'h6, 4'b0001, rd, ak);
        din[0] = 32'h00;
        step();
        xact(BASE, 1'b1, 0, 4'b0000, rd, ak);
        chk("sticky_clr", rd, 32'h01);

        xact(CTRLA, 1'b0, 32'h0, 4'b0001, rd, ak);
        din[1] = 32'h1234;
        step();
        usnap = 1'b1;
        step();
        usnap = 1'b0;
        din[1] = 32'h5678;
        step();
        xact(BASE + 4, 1'b1, 0, 4'b0000, rd, ak);
        chk("snap_ch1", rd, 32'h1234);
        xact(CTRLA, 1'b1, 0, 4'b0000, rd, ak);
        chk("snap_cnt1", rd, 32'h0001_0400);

        abus = CTRLA;
        rnw = 1'b0;
        dbus = 32'h1;
        be = 4'b0001;
        sel = 1'b1;
        usnap = 1'b1;
        step();
        usnap = 1'b0;
        sel = 1'b0;
        rnw = 1'b1;
        step();
        step();
        xact(CTRLA, 1'b1, 0, 4'b0000, rd, ak);
        chk("snap_coinc", rd, 32'h0002_0400);

        usnap = 1'b1;
        repeat (65534) step();
        usnap = 1'b0;
        xact(CTRLA, 1'b1, 0, 4'b0000, rd, ak);
        chk("snap_wrap", rd, 32'h0000_0400);

        for (int k = 0; k < 300; k++) begin
            int op;
            logic [31:0] a;
            for (int c = 0; c < NCH; c++) din[c] = $urandom;
            usnap = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 3);
            a = BASE + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            if (op == 0) begin
                step();
            end else if (op == 3) begin
                a = BASE + 4 * $urandom_range(0, 5);
                xact(a, 1'b0, $urandom, 4'($urandom), rd, ak);
            end else begin
                xact(a, 1'b1, 0, 4'b0000, rd, ak);
            end
        end
        usnap = 1'b0;

        abus = CTRLA;
        rnw = 1'b1;
        sel = 1'b1;
        step();
        chk("pre_rst_ack", {31'b0, ack}, 32'h1);
        sel = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'h0);
        chk("midrst_dbus", sl_dbus, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        xact(CTRLA, 1'b1, 0, 4'b0000, rd, ak);
        chk("post_rst_ctrl", rd, 32'h0000_0404);

        xact(32'h0110_0200, 1'b1, 0, 4'b0000, rd, ak);
        chk("oow_hi", {31'b0, ak}, 32'h0);
        xact(32'h0110_00FC, 1'b1, 0, 4'b0000, rd, ak);
        chk("oow_lo", {31'b0, ak}, 32'h0);
        xact(BASE + 20, 1'b1, 0, 4'b0000, rd, ak);
        chk("unmapped_rd", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
